serial_sub16: RTL

- Multi-cycle two's-complement subtractor computing diff = a - b. It processes BITS_PER_CYCLE bits per clock, LSB first, through a chain of full-subtractor cells, and carries the borrow between cycles in a flop.
- It is the inverse operator to the team's 16-bit ripple-carry adder. It is intended for area-constrained datapaths where a full-width borrow chain is not wanted.
- Operands use a valid/ready handshake on input. The result is held under valid/ready on output.

---
 rtl/sub_pkg.sv | 27 ++
 rtl/full_sub1.sv | 22 ++
 rtl/serial_sub16.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the serial subtractor:
//   - subState_t   : controller states (IDLE, RUN, DONE)
//   - DEFAULT_*    : default operand width and bits processed per cycle
//   - countWidth() : width of the step counter for a given configuration
// ---------------------------------------------------------------------------
package sub_pkg;

  localparam int DEFAULT_WIDTH          = 16;
  localparam int DEFAULT_BITS_PER_CYCLE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } subState_t;

  // clog2 of the number of RUN steps, never narrower than one bit so the
  // counter stays a legal vector when a single step covers the whole word.
  function automatic int countWidth(input int width, input int bitsPerCycle);
    int steps;
    steps = width / bitsPerCycle;
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/full_sub1.sv
// ---------------------------------------------------------------------------
// full_sub1
// Combinational single-bit full subtractor computing x - y - bin.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in from the less significant bit
//   d    : difference bit
//   bout : borrow out to the more significant bit
// ---------------------------------------------------------------------------
module full_sub1 (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub16.sv
// ---------------------------------------------------------------------------
// serial_sub16
// Multi-cycle two's-complement subtractor, diff = a - b. Processes
// BITS_PER_CYCLE bits per clock, LSB first, through a chain of full_sub1
// cells; the borrow between cycles lives in a flop.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   in_valid / in_ready : operand handshake, accepted only in IDLE
//   a, b                : minuend and subtrahend, sampled on acceptance
//   out_valid/out_ready : result handshake, valid only in DONE
//   diff                : (a - b) mod 2^WIDTH
//   borrow              : unsigned a < b
//   ovf                 : signed overflow of a - b
//   zero                : diff == 0
// ---------------------------------------------------------------------------
module serial_sub16
  import sub_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = countWidth(WIDTH, BITS_PER_CYCLE);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  generate
    if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_badParam
      $error("serial_sub16: BITS_PER_CYCLE (%0d) must divide WIDTH (%0d)",
             BITS_PER_CYCLE, WIDTH);
    end
  endgenerate

  subState_t r_state;
  subState_t w_nextState;

  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic [WIDTH-1:0]        r_res;
  logic [WIDTH-1:0]        w_resNext;
  logic [CW-1:0]           r_cnt;
  logic                    r_borrow;
  logic                    r_aMsb;
  logic                    r_bMsb;
  logic [BITS_PER_CYCLE-1:0] w_d;
  logic [BITS_PER_CYCLE:0]   w_bchain;
  logic                    w_lastStep;

  // Borrow ripples LSB to MSB inside the cycle, seeded by the borrow flop.
  assign w_bchain[0] = r_borrow;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
    full_sub1 u_cell (
      .x    (r_a[i]),
      .y    (r_b[i]),
      .bin  (w_bchain[i]),
      .d    (w_d[i]),
      .bout (w_bchain[i+1])
    );
  end

  // New difference bits enter at the top; after the final step the register
  // holds the whole result with bit 0 at the bottom.
  assign w_resNext  = WIDTH'({w_d, r_res} >> BITS_PER_CYCLE);
  assign w_lastStep = (r_cnt == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = RUN;
      end
      RUN: begin
        if (w_lastStep) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: operand capture, per-step shifting, and result/flag latch on
  // the final step so the visible outputs only change when a result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_aMsb   <= 1'b0;
      r_bMsb   <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_aMsb   <= a[WIDTH-1];
            r_bMsb   <= b[WIDTH-1];
          end
        end
        RUN: begin
          r_a      <= r_a >> BITS_PER_CYCLE;
          r_b      <= r_b >> BITS_PER_CYCLE;
          r_res    <= w_resNext;
          r_borrow <= w_bchain[BITS_PER_CYCLE];
          r_cnt    <= r_cnt + CW'(1);
          if (w_lastStep) begin
            diff   <= w_resNext;
            borrow <= w_bchain[BITS_PER_CYCLE];
            ovf    <= (r_aMsb != r_bMsb) && (w_resNext[WIDTH-1] != r_aMsb);
            zero   <= (w_resNext == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
